// File: rtl/cpu_types_pkg.sv
// Shared cache types: controller states, word type, default geometry.
// Pure declarations, no logic, so no latency.
// Not applicable: this file carries no flow control.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, DONE} dcache_state_t;

  localparam int DCACHE_WAYS  = 2;
  localparam int DCACHE_SETS  = 8;
  localparam int DCACHE_WORDS = 2;

  // Width of a field able to hold 0..n-1.
  // Never returns zero, so a one-entry dimension still gets a legal vector.
  function automatic int bits_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set age-based LRU. Age 0 is most recent and WAYS-1 is least recent.
// Victim is combinational from query_set and valid_vec; a touch updates ages on the next edge.
// No backpressure: a touch is accepted on every cycle that touch_en is high.
module dcache_lru
  import cpu_types_pkg::*;
#(
  parameter int WAYS = DCACHE_WAYS,
  parameter int SETS = DCACHE_SETS,
  localparam int WAY_W = bits_min1(WAYS),
  localparam int IDX_W = bits_min1(SETS)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [IDX_W-1:0] query_set,
  input  logic [WAYS-1:0]  valid_vec,
  output logic [WAY_W-1:0] victim_way
);

  logic [WAY_W-1:0] ages [SETS][WAYS];
  logic [WAY_W-1:0] best_age;
  logic             found;

  // Touched way becomes youngest; ways younger than it each age by one.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          ages[s][w] <= WAY_W'(w);
    end else if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          ages[touch_set][w] <= '0;
        else if (ages[touch_set][w] < ages[touch_set][touch_way])
          ages[touch_set][w] <= ages[touch_set][w] + 1'b1;
      end
    end
  end

  // Victim selection: the lowest invalid way, otherwise the oldest way.
  always_comb begin
    victim_way = '0;
    found      = 1'b0;
    best_age   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_vec[w] && !found) begin
        victim_way = WAY_W'(w);
        found      = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages[query_set][w] > best_age) begin
          best_age   = ages[query_set][w];
          victim_way = WAY_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative write-back data cache with LRU, LL/SC link register and halt-time flush.
// Hit: dhit in the same cycle. Miss: 1 + (write-back) + fetch transfers + 1 cycles.
// Memory backpressure via dwait stalls each word; the datapath holds its request until dhit.
module dcache_nway
  import cpu_types_pkg::*;
#(
  parameter int WAYS  = DCACHE_WAYS,
  parameter int SETS  = DCACHE_SETS,
  parameter int WORDS = DCACHE_WORDS
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int DTAG_W = 30 - OFF_W - IDX_W;
  localparam int OFF_B  = bits_min1(WORDS);
  localparam int WAY_W  = bits_min1(WAYS);

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [DTAG_W-1:0]       tag;
    word_t [WORDS-1:0]       data;
  } dcache_frame_t;

  dcache_state_t state, next_state;
  dcache_frame_t frames [SETS][WAYS];
  dcache_frame_t fent, mframe;

  logic [OFF_B-1:0]  wcnt;
  logic [IDX_W-1:0]  fset;
  logic [WAY_W-1:0]  fway, miss_way, hit_way, victim_way, touch_way;
  logic              link_vld;
  logic [31:0]       link_addr;

  logic [DTAG_W-1:0] req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_B-1:0]  req_off;
  logic [WAYS-1:0]   valid_vec;
  logic              tag_hit, req, sc_op, link_match, sc_fail;
  logic              wr_hit, fill_done, touch_en, wlast, flast;

  // Memory word address of word o of block (tag t, index i).
  function automatic logic [31:0] blk_addr(input logic [DTAG_W-1:0] t,
                                           input logic [IDX_W-1:0]  i,
                                           input logic [OFF_B-1:0]  o);
    logic [31:0] a;
    a = '0;
    a[31 -: DTAG_W]      = t;
    a[2+OFF_W +: IDX_W]  = i;
    if (WORDS > 1) a[2 +: OFF_B] = o;
    return a;
  endfunction

  assign req_tag    = dmemaddr[31 -: DTAG_W];
  assign req_idx    = dmemaddr[2+OFF_W +: IDX_W];
  assign req_off    = OFF_B'((dmemaddr >> 2) & 32'(WORDS - 1));
  assign req        = dmemREN | dmemWEN;
  assign sc_op      = datomic & dmemWEN;
  assign link_match = link_vld & (link_addr == dmemaddr);
  assign sc_fail    = sc_op & ~link_match;
  assign wr_hit     = dhit & dmemWEN & ~sc_fail;
  assign wlast      = (wcnt == OFF_B'(WORDS - 1));
  assign flast      = (fset == IDX_W'(SETS - 1)) && (fway == WAY_W'(WAYS - 1));
  assign fill_done  = (state == FETCH) & ~dwait & wlast;
  assign touch_en   = (dhit & ~sc_fail) | fill_done;
  assign touch_way  = fill_done ? miss_way : hit_way;
  assign fent       = frames[fset][fway];
  assign mframe     = frames[req_idx][miss_way];

  dcache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk        (CLK),
    .nrst       (nRST),
    .touch_en   (touch_en),
    .touch_set  (req_idx),
    .touch_way  (touch_way),
    .query_set  (req_idx),
    .valid_vec  (valid_vec),
    .victim_way (victim_way)
  );

  // Tag compare across the ways of the addressed set; lowest matching way wins.
  always_comb begin
    tag_hit   = 1'b0;
    hit_way   = '0;
    valid_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_vec[w] = frames[req_idx][w].valid;
      if (!tag_hit && frames[req_idx][w].valid && frames[req_idx][w].tag == req_tag) begin
        tag_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Controller state register.
  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and port outputs; memory ports stay quiet outside WB/FETCH/FLUSH.
  always_comb begin
    next_state = state;
    dhit       = 1'b0;
    dmemload   = '0;
    flushed    = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    daddr      = '0;
    dstore     = '0;
    case (state)
      IDLE: begin
        if (req) begin
          // A failing SC completes immediately and never goes to memory.
          if (sc_fail || tag_hit) begin
            dhit = 1'b1;
            if (sc_op)        dmemload = {31'b0, ~sc_fail};
            else if (dmemREN) dmemload = frames[req_idx][hit_way].data[req_off];
          end else if (frames[req_idx][victim_way].dirty) begin
            next_state = WB;
          end else begin
            next_state = FETCH;
          end
        end else if (halt) begin
          next_state = FLUSH;
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(mframe.tag, req_idx, wcnt);
        dstore = mframe.data[wcnt];
        if (!dwait && wlast) next_state = FETCH;
      end
      FETCH: begin
        dREN  = 1'b1;
        daddr = blk_addr(req_tag, req_idx, wcnt);
        if (!dwait && wlast) next_state = IDLE;
      end
      FLUSH: begin
        if (fent.dirty) begin
          dWEN   = 1'b1;
          daddr  = blk_addr(fent.tag, fset, wcnt);
          dstore = fent.data[wcnt];
          if (!dwait && wlast && flast) next_state = DONE;
        end else if (flast) begin
          next_state = DONE;
        end
      end
      DONE:    flushed = 1'b1;
      default: next_state = IDLE;
    endcase
  end

  // Frame array, word counter, flush walker and link register updates.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          frames[s][w] <= '0;
      wcnt      <= '0;
      fset      <= '0;
      fway      <= '0;
      miss_way  <= '0;
      link_vld  <= 1'b0;
      link_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dhit) begin
            if (wr_hit) begin
              frames[req_idx][hit_way].data[req_off] <= dmemstore;
              frames[req_idx][hit_way].dirty         <= 1'b1;
              if (link_match) link_vld <= 1'b0;
            end
            if (sc_op) link_vld <= 1'b0;
            if (dmemREN && datomic) begin
              link_vld  <= 1'b1;
              link_addr <= dmemaddr;
            end
          end else if (req) begin
            miss_way <= victim_way;
            wcnt     <= '0;
          end else if (halt) begin
            fset <= '0;
            fway <= '0;
            wcnt <= '0;
          end
        end
        WB: begin
          if (!dwait) wcnt <= wlast ? '0 : wcnt + 1'b1;
        end
        FETCH: begin
          if (!dwait) begin
            frames[req_idx][miss_way].data[wcnt] <= dload;
            wcnt <= wlast ? '0 : wcnt + 1'b1;
            if (wlast) begin
              frames[req_idx][miss_way].valid <= 1'b1;
              frames[req_idx][miss_way].dirty <= 1'b0;
              frames[req_idx][miss_way].tag   <= req_tag;
            end
          end
        end
        FLUSH: begin
          // Advance to the next (set,way) once an entry is clean or fully written.
          if (!fent.dirty || (!dwait && wlast)) begin
            if (fent.dirty) frames[fset][fway].dirty <= 1'b0;
            wcnt <= '0;
            if (fway == WAY_W'(WAYS - 1)) begin
              fway <= '0;
              fset <= fset + 1'b1;
            end else begin
              fway <= fway + 1'b1;
            end
          end else if (!dwait) begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway at WAYS=2, SETS=8, WORDS=2 against a word-addressed memory model.
// Memory model holds dwait high for mem_lat cycles per word, then completes the transfer.
// Every expected value below is hand-derived from the address map and LRU order.
module tb_dcache_nway;

  logic        CLK = 1'b0;
  logic        nRST, halt, dmemREN, dmemWEN, datomic, dwait;
  logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;
  logic        dhit, flushed, dREN, dWEN;

  logic [31:0] mem [1024];
  int          mem_lat = 0;
  int          mcnt = 0;
  logic [31:0] wr_log[$], wr_dat[$], rd_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd;
  int          cy;

  dcache_nway #(.WAYS(2), .SETS(8), .WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .datomic(datomic), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit),
    .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait)
  );

  always #5 CLK = ~CLK;

  assign dwait = ~((dREN | dWEN) & (mcnt >= mem_lat));
  assign dload = mem[daddr[11:2]];

  always @(posedge CLK) begin
    if (!nRST) begin
      mcnt <= 0;
    end else if (dREN || dWEN) begin
      if (!dwait) begin
        mcnt <= 0;
        if (dWEN) begin
          mem[daddr[11:2]] <= dstore;
          wr_log.push_back(daddr);
          wr_dat.push_back(dstore);
        end
        if (dREN) rd_log.push_back(daddr);
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One datapath request held until dhit; returns load data and cycles waited before dhit.
  task automatic access(input logic ren, input logic wen, input logic atom,
                        input logic [31:0] addr, input logic [31:0] wdat,
                        output logic [31:0] rdat, output int cyc);
    @(negedge CLK);
    dmemREN = ren; dmemWEN = wen; datomic = atom; dmemaddr = addr; dmemstore = wdat;
    cyc = 0;
    #1;
    while (!dhit && cyc < 300) begin
      @(negedge CLK);
      cyc++;
    end
    chk("dhit_seen", {31'b0, dhit}, 32'd1);
    rdat = dmemload;
    @(posedge CLK);
    #1;
    dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
  endtask

  task automatic clear_logs();
    wr_log.delete(); wr_dat.delete(); rd_log.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i * 4);
    nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    dmemaddr = '0; dmemstore = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_dhit",     {31'b0, dhit},    32'd0);
    chk("rst_dREN",     {31'b0, dREN},    32'd0);
    chk("rst_dWEN",     {31'b0, dWEN},    32'd0);
    chk("rst_flushed",  {31'b0, flushed}, 32'd0);
    chk("rst_daddr",    daddr,            32'd0);
    chk("rst_dstore",   dstore,           32'd0);
    chk("rst_dmemload", dmemload,         32'd0);
    nRST = 1'b1;

    // Cold load: FETCH 0x100, 0x104, hit on the fourth cycle.
    clear_logs();
    access(1, 0, 0, 32'h100, 0, rd, cy);
    chk("t1_data",   rd, 32'hA000_0100);
    chk("t1_cycles", cy, 32'd3);
    chk("t1_rd_cnt", rd_log.size(), 32'd2);
    chk("t1_rd0",    rd_log[0], 32'h100);
    chk("t1_rd1",    rd_log[1], 32'h104);
    access(1, 0, 0, 32'h104, 0, rd, cy);
    chk("t1_hit_data",   rd, 32'hA000_0104);
    chk("t1_hit_cycles", cy, 32'd0);

    // Store hit, then reload.
    access(0, 1, 0, 32'h100, 32'hDEAD_BEEF, rd, cy);
    chk("t2_st_cycles", cy, 32'd0);
    access(1, 0, 0, 32'h100, 0, rd, cy);
    chk("t2_reload", rd, 32'hDEAD_BEEF);
    chk("t2_no_wr",  wr_log.size(), 32'd0);

    // Three tags in set 0: 0x200 fills way1, 0x300 evicts dirty 0x100 from way0.
    clear_logs();
    access(1, 0, 0, 32'h200, 0, rd, cy);
    chk("t3_200_data", rd, 32'hA000_0200);
    clear_logs();
    access(1, 0, 0, 32'h300, 0, rd, cy);
    chk("t3_300_data",   rd, 32'hA000_0300);
    chk("t3_300_cycles", cy, 32'd5);
    chk("t3_wr_cnt", wr_log.size(), 32'd2);
    chk("t3_wr0",    wr_log[0], 32'h100);
    chk("t3_wr1",    wr_log[1], 32'h104);
    chk("t3_wd0",    wr_dat[0], 32'hDEAD_BEEF);
    chk("t3_wd1",    wr_dat[1], 32'hA000_0104);
    chk("t3_rd0",    rd_log[0], 32'h300);
    chk("t3_rd1",    rd_log[1], 32'h304);
    // 0x200 (way1) is now oldest and clean: refetch 0x100 without write-back.
    clear_logs();
    access(1, 0, 0, 32'h100, 0, rd, cy);
    chk("t3_wb_data",   rd, 32'hDEAD_BEEF);
    chk("t3_wb_cycles", cy, 32'd3);
    chk("t3_wb_nowr",   wr_log.size(), 32'd0);

    // LL/SC on 0x40 (set 0, replaces clean 0x300 in way0).
    access(1, 0, 1, 32'h40, 0, rd, cy);
    chk("t4_ll_data", rd, 32'hA000_0040);
    access(0, 1, 1, 32'h40, 32'h1234_5678, rd, cy);
    chk("t4_sc1", rd, 32'd1);
    access(1, 0, 0, 32'h40, 0, rd, cy);
    chk("t4_sc1_word", rd, 32'h1234_5678);
    access(0, 1, 1, 32'h40, 32'hCAFE_F00D, rd, cy);
    chk("t4_sc2",        rd, 32'd0);
    chk("t4_sc2_cycles", cy, 32'd0);
    access(1, 0, 0, 32'h40, 0, rd, cy);
    chk("t4_sc2_word", rd, 32'h1234_5678);
    access(1, 0, 1, 32'h40, 0, rd, cy);
    access(0, 1, 0, 32'h40, 32'h0000_0055, rd, cy);
    access(0, 1, 1, 32'h40, 32'h0000_0077, rd, cy);
    chk("t4_sc_after_st", rd, 32'd0);
    access(1, 0, 0, 32'h40, 0, rd, cy);
    chk("t4_final_word", rd, 32'h0000_0055);

    // Slow memory: 5 busy cycles then one completing cycle per word.
    clear_logs();
    mem_lat = 5;
    access(1, 0, 0, 32'h08, 0, rd, cy);
    mem_lat = 0;
    chk("t5_data",   rd, 32'hA000_0008);
    chk("t5_cycles", cy, 32'd13);
    chk("t5_rd_cnt", rd_log.size(), 32'd2);
    chk("t5_rd0",    rd_log[0], 32'h08);
    chk("t5_rd1",    rd_log[1], 32'h0C);

    // Dirty set0/way0 (0x40 block) and set1/way0 (0x08 block), then halt.
    access(0, 1, 0, 32'h08, 32'h1111_1111, rd, cy);
    clear_logs();
    @(negedge CLK);
    halt = 1'b1;
    cy = 0;
    while (!flushed && cy < 500) begin
      @(negedge CLK);
      cy++;
    end
    chk("t6_flushed",  {31'b0, flushed}, 32'd1);
    chk("t6_wr_cnt",   wr_log.size(), 32'd4);
    chk("t6_wr0",      wr_log[0], 32'h40);
    chk("t6_wr1",      wr_log[1], 32'h44);
    chk("t6_wr2",      wr_log[2], 32'h08);
    chk("t6_wr3",      wr_log[3], 32'h0C);
    chk("t6_wd0",      wr_dat[0], 32'h0000_0055);
    chk("t6_wd1",      wr_dat[1], 32'hA000_0044);
    chk("t6_wd2",      wr_dat[2], 32'h1111_1111);
    chk("t6_wd3",      wr_dat[3], 32'hA000_000C);
    chk("t6_no_rd",    rd_log.size(), 32'd0);
    repeat (5) @(negedge CLK);
    chk("t6_held",     {31'b0, flushed}, 32'd1);
    chk("t6_quiet",    {31'b0, dWEN | dREN}, 32'd0);
    chk("t6_wr_final", wr_log.size(), 32'd4);
    halt = 1'b0;
    nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("t6_rst_flushed", {31'b0, flushed}, 32'd0);
    nRST = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
